// File: rtl/inv_result_fifo_if.sv
`default_nettype none
// ============================================================================
// inv_result_fifo_if : ALU capture / FIFO drain bundle for inv_result_fifo
// Revision 1.0
// ============================================================================
interface inv_result_fifo_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [23:0]      alu_result;
   logic             alu_cont;
   logic [23:0]      out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             drop;

   modport slave (
      input  alu_result, alu_cont, out_ready,
      output out_data, out_valid, count, full, drop
   );

   modport master (
      output alu_result, alu_cont, out_ready,
      input  out_data, out_valid, count, full, drop
   );
endinterface
`default_nettype wire

// File: rtl/inv_result_fifo.sv
`default_nettype none
// ============================================================================
// inv_result_fifo : edge-triggered capture of sign-magnitude ALU results into
//                   a show-ahead FIFO of two's complement values
// Revision 1.0
// ============================================================================
module inv_result_fifo #(
   parameter int DEPTH = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   inv_result_fifo_if.slave   bus
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_cnt_w  = c_addr_w + 1;
   localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
   localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

   logic [23:0]         r_mem [DEPTH];
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                r_cont_q;
   logic                r_drop;

   logic [23:0]         w_mag;
   logic [23:0]         w_conv;
   logic                w_capture;
   logic                w_valid;
   logic                w_full;
   logic                w_pop;
   logic                w_push;

   // A held alu_cont is one result; only its rising edge is a capture.
   assign w_capture = bus.alu_cont & ~r_cont_q;

   // Negative zero has no two's complement form distinct from zero.
   assign w_mag  = {1'b0, bus.alu_result[22:0]};
   assign w_conv = (bus.alu_result[23] && (w_mag != 24'd0)) ? (24'd0 - w_mag) : w_mag;

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == c_depth);
   assign w_pop   = w_valid & bus.out_ready;
   // A pop frees the slot in the same edge, so full-with-pop still accepts.
   assign w_push  = w_capture & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_cont_q <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_cont_q <= bus.alu_cont;
         r_drop   <= w_capture & w_full & ~w_pop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: reads are gated by count.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= w_conv;
      end
   end

   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_valid ? r_mem[r_rd_ptr] : 24'd0;
   assign bus.count     = r_count;
   assign bus.full      = w_full;
   assign bus.drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_inv_result_fifo.sv
`default_nettype none
// ============================================================================
// tb_inv_result_fifo : vector table, directed corner sequences and random
//                      traffic against a queue-based reference model
// Revision 1.0
// ============================================================================
module tb_inv_result_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inv_result_fifo_if #(.DEPTH(DEPTH)) bus ();

   inv_result_fifo #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int vectors    = 0;
   int miscompares = 0;

   logic [23:0] mq[$];
   bit          m_cont;
   bit          m_drop;

   typedef struct {
      logic        rst;
      logic        cont;
      logic [23:0] res;
      logic        ready;
      logic        v;
      logic [23:0] d;
      int          c;
      logic        f;
      logic        dr;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [23:0] to_twos(logic [23:0] sm);
      int mag;
      int v;
      mag = int'(sm[22:0]);
      v   = sm[23] ? -mag : mag;
      return v[23:0];
   endfunction

   // Advance the model with the inputs about to be sampled, then take the edge.
   task automatic tick();
      bit cap;
      bit pop;
      if (rst) begin
         mq.delete();
         m_cont = 1'b0;
         m_drop = 1'b0;
      end else begin
         cap    = bus.alu_cont && !m_cont;
         pop    = (mq.size() != 0) && bus.out_ready;
         m_drop = 1'b0;
         if (pop) void'(mq.pop_front());
         if (cap) begin
            if (mq.size() < DEPTH) mq.push_back(to_twos(bus.alu_result));
            else                   m_drop = 1'b1;
         end
         m_cont = bus.alu_cont;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic r, input logic cont, input logic [23:0] res, input logic rdy);
      rst            = r;
      bus.alu_cont   = cont;
      bus.alu_result = res;
      bus.out_ready  = rdy;
      tick();
   endtask

   task automatic check(input string name, input logic v, input logic [23:0] d,
                        input int c, input logic f, input logic dr);
      vectors++;
      if (bus.out_valid !== v || bus.out_data !== d || bus.count !== CW'(c) ||
          bus.full !== f || bus.drop !== dr) begin
         miscompares++;
         $display("FAIL %s: got valid=%0b data=%h count=%0d full=%0b drop=%0b; want valid=%0b data=%h count=%0d full=%0b drop=%0b",
                  name, bus.out_valid, bus.out_data, bus.count, bus.full, bus.drop,
                  v, d, c, f, dr);
      end
   endtask

   task automatic check_model(input string name);
      check(name, mq.size() != 0, (mq.size() != 0) ? mq[0] : 24'h0,
            mq.size(), mq.size() == DEPTH, m_drop);
   endtask

   task automatic do_reset();
      apply(1'b1, 1'b0, 24'h0, 1'b0);
      apply(1'b0, 1'b0, 24'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.alu_cont   = 1'b0;
      bus.alu_result = 24'h0;
      bus.out_ready  = 1'b0;

      //         rst   cont  res        rdy   v     data       c  f     drop
      tbl[0] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 24'h002000, 1'b1, 1'b1, 24'h002000, 1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 24'h800800, 1'b0, 1'b1, 24'hFFF800, 1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 24'h800000, 1'b0, 1'b1, 24'h000000, 1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 24'h800001, 1, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 24'h123456, 1'b1, 1'b0, 24'h000000, 0, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].rst, tbl[i].cont, tbl[i].res, tbl[i].ready);
         check($sformatf("table[%0d]", i), tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].f, tbl[i].dr);
      end

      // Held alu_cont counts once.
      do_reset();
      for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 24'h004000, 1'b0);
      check("hold_one", 1'b1, 24'h004000, 1, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 24'h0, 1'b0);

      // Overflow: fifth capture dropped, drop lasts one cycle, order kept.
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         apply(1'b0, 1'b1, 24'(k << 14), 1'b0);
         if (k == 5) check("full_drop", 1'b1, 24'h004000, 4, 1'b1, 1'b1);
         apply(1'b0, 1'b0, 24'h0, 1'b0);
         if (k == 5) check("drop_once", 1'b1, 24'h004000, 4, 1'b1, 1'b0);
      end
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("drain[%0d]", k), 1'b1, 24'(k << 14), 5 - k, k == 1, 1'b0);
         apply(1'b0, 1'b0, 24'h0, 1'b1);
      end
      check("drain_empty", 1'b0, 24'h0, 0, 1'b0, 1'b0);

      // Full with simultaneous capture and pop.
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         apply(1'b0, 1'b1, 24'(k << 14), 1'b0);
         apply(1'b0, 1'b0, 24'h0, 1'b0);
      end
      apply(1'b0, 1'b1, 24'(5 << 14), 1'b1);
      check("full_cap_pop", 1'b1, 24'h008000, 4, 1'b1, 1'b0);
      apply(1'b0, 1'b0, 24'h0, 1'b0);
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("drain2[%0d]", k), 1'b1, 24'(k << 14), 6 - k, k == 2, 1'b0);
         apply(1'b0, 1'b0, 24'h0, 1'b1);
      end

      // Reset mid-operation with alu_cont rising during reset.
      do_reset();
      apply(1'b0, 1'b1, 24'h004000, 1'b0);
      apply(1'b0, 1'b0, 24'h0, 1'b0);
      apply(1'b0, 1'b1, 24'h008000, 1'b0);
      apply(1'b0, 1'b0, 24'h0, 1'b0);
      check("two_stored", 1'b1, 24'h004000, 2, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 24'h00C000, 1'b0);
      check("rst_mid", 1'b0, 24'h0, 0, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 24'h00C000, 1'b0);
      check("post_rst_cap", 1'b1, 24'h00C000, 1, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 24'h00C000, 1'b0);
      check("post_rst_hold", 1'b1, 24'h00C000, 1, 1'b0, 1'b0);

      // Random traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         logic [23:0] res;
         res = ($urandom_range(0, 15) == 0) ? 24'h800000 : 24'($urandom);
         apply($urandom_range(0, 99) < 2,
               1'($urandom_range(0, 1)),
               res,
               (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
         check_model($sformatf("rand[%0d]", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
